// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg
// Shared constants for the memory port arbiter and its neighbours:
// exception code width and values reported back to requesters, and the
// access width codes carried on the router port.
package mem_port_arbiter_pkg;

   localparam int EXCEPTION_LEN = 4;

   localparam logic [EXCEPTION_LEN-1:0] EXCEP_OK                = 4'd0;
   localparam logic [EXCEPTION_LEN-1:0] EXCEP_INVALID_MEM_READ  = 4'd5;
   localparam logic [EXCEPTION_LEN-1:0] EXCEP_INVALID_MEM_WRITE = 4'd7;

   localparam logic [1:0] MEM_WIDTH_BYTE = 2'd0;
   localparam logic [1:0] MEM_WIDTH_HALF = 2'd1;
   localparam logic [1:0] MEM_WIDTH_WORD = 2'd2;

endpackage

// File: rtl/mem_port_arbiter_rr_pick.sv
// rr_pick
// Purely combinational round-robin picker. Starting one position after
// 'last' (wrapping modulo N), it selects the first set bit of 'eligible'.
// Ports:
//   eligible  in   N       candidate vector
//   last      in   IW      index of the most recently served candidate
//   grant     out  N       one-hot winner (all zero when none eligible)
//   index     out  IW      binary index of the winner
//   any       out  1       a winner exists
module rr_pick #(
   parameter int N = 3,
   localparam int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  eligible,
   input  logic [IW-1:0] last,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] index,
   output logic          any
);

   logic [IW-1:0] pos;

   // Walk the N positions in priority order; the first eligible one wins
   // and later positions are ignored once 'any' is set.
   always_comb begin
      grant = '0;
      index = '0;
      any   = 1'b0;
      pos   = '0;
      for (int k = 1; k <= N; k++) begin
         pos = IW'((int'(last) + k) % N);
         if (!any && eligible[pos]) begin
            grant[pos] = 1'b1;
            index      = pos;
            any        = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares router port B among N_REQ requesters with round-robin arbitration.
// A winning request is latched and driven to the router for exactly one
// transaction, which ends on router finish, router exception or timeout.
// The owner then receives a one-cycle done pulse with data and exception.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_*_In                 packed per-requester request fields
//   grant_Out                one-hot owner of the current transaction
//   req_done_Out             one-cycle completion pulse to the owner
//   req_data_Out/exception   completion result, valid with done
//   m_*_Out                  request fields towards the router
//   m_operationOK_In, m_data_In, m_exception_In   router response
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int N_REQ   = 3,
   parameter int TIMEOUT = 255
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [N_REQ-1:0]         req_valid_In,
   input  logic [N_REQ*32-1:0]      req_addr_In,
   input  logic [N_REQ*32-1:0]      req_data_In,
   input  logic [N_REQ*2-1:0]       req_dataWidth_In,
   input  logic [N_REQ-1:0]         req_isRead_In,
   output logic [N_REQ-1:0]         grant_Out,
   output logic [N_REQ-1:0]         req_done_Out,
   output logic [31:0]              req_data_Out,
   output logic [EXCEPTION_LEN-1:0] req_exception_Out,
   output logic [31:0]              m_addr_Out,
   output logic [31:0]              m_data_Out,
   output logic [1:0]               m_dataWidth_Out,
   output logic                     m_isRead_Out,
   output logic                     m_inputValid_Out,
   input  logic                     m_operationOK_In,
   input  logic [31:0]              m_data_In,
   input  logic [EXCEPTION_LEN-1:0] m_exception_In
);

   localparam int IW = $clog2(N_REQ);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      BUSY    = 2'd1,
      RELEASE = 2'd2
   } state_t;

   state_t                   state;
   logic [IW-1:0]            last;
   logic [IW-1:0]            owner;
   logic [N_REQ-1:0]         mask;
   logic [7:0]               busy_cnt;
   logic [7:0]               cnt_next;

   logic [N_REQ-1:0]         eligible;
   logic [N_REQ-1:0]         pick_grant;
   logic [IW-1:0]            pick_index;
   logic                     pick_any;

   logic [31:0]              sel_addr;
   logic [31:0]              sel_data;
   logic [1:0]               sel_width;
   logic                     sel_read;

   logic                     finish;
   logic [31:0]              fin_data;
   logic [EXCEPTION_LEN-1:0] fin_exc;

   // The requester completed in the previous cycle sits out one IDLE cycle.
   assign eligible = req_valid_In & ~mask;
   assign cnt_next = busy_cnt + 8'd1;

   rr_pick #(.N(N_REQ)) u_pick (
      .eligible (eligible),
      .last     (last),
      .grant    (pick_grant),
      .index    (pick_index),
      .any      (pick_any)
   );

   // One-hot mux of the winning requester's fields.
   always_comb begin
      sel_addr  = '0;
      sel_data  = '0;
      sel_width = '0;
      sel_read  = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
         if (pick_grant[i]) begin
            sel_addr  = req_addr_In[32*i +: 32];
            sel_data  = req_data_In[32*i +: 32];
            sel_width = req_dataWidth_In[2*i +: 2];
            sel_read  = req_isRead_In[i];
         end
      end
   end

   // Completion conditions while BUSY: router exception beats router finish,
   // which beats the timeout. busy_cnt counts BUSY cycles already spent, so
   // cnt_next is the count including the current cycle.
   always_comb begin
      finish   = 1'b0;
      fin_data = '0;
      fin_exc  = EXCEP_OK;
      if (m_exception_In != EXCEP_OK) begin
         finish  = 1'b1;
         fin_exc = m_exception_In;
      end else if (m_operationOK_In) begin
         finish   = 1'b1;
         fin_data = m_data_In;
      end else if (cnt_next == 8'(TIMEOUT)) begin
         finish  = 1'b1;
         fin_exc = m_isRead_Out ? EXCEP_INVALID_MEM_READ : EXCEP_INVALID_MEM_WRITE;
      end
   end

   // Arbitration FSM with registered outputs. 'last' starts at N_REQ-1 so
   // requester 0 has first priority; it is updated when the transaction
   // completes, which is only observed once the FSM is back in IDLE.
   always_ff @(posedge clk) begin
      if (rst) begin
         state             <= IDLE;
         last              <= IW'(N_REQ - 1);
         owner             <= '0;
         mask              <= '0;
         busy_cnt          <= '0;
         grant_Out         <= '0;
         req_done_Out      <= '0;
         req_data_Out      <= '0;
         req_exception_Out <= EXCEP_OK;
         m_addr_Out        <= '0;
         m_data_Out        <= '0;
         m_dataWidth_Out   <= '0;
         m_isRead_Out      <= 1'b0;
         m_inputValid_Out  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               mask <= '0;
               if (pick_any) begin
                  m_addr_Out       <= sel_addr;
                  m_data_Out       <= sel_data;
                  m_dataWidth_Out  <= sel_width;
                  m_isRead_Out     <= sel_read;
                  m_inputValid_Out <= 1'b1;
                  owner            <= pick_index;
                  grant_Out        <= pick_grant;
                  busy_cnt         <= '0;
                  state            <= BUSY;
               end
            end
            BUSY: begin
               busy_cnt <= cnt_next;
               if (finish) begin
                  m_inputValid_Out  <= 1'b0;
                  req_done_Out      <= grant_Out;
                  req_data_Out      <= fin_data;
                  req_exception_Out <= fin_exc;
                  last              <= owner;
                  state             <= RELEASE;
               end
            end
            RELEASE: begin
               req_done_Out <= '0;
               mask         <= grant_Out;
               grant_Out    <= '0;
               state        <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Directed bench for mem_port_arbiter with three requesters and TIMEOUT = 4.
// The router side is driven directly by the stimulus sequence. Inputs change
// 1 time unit after a rising edge and outputs are sampled at that point.
module tb_mem_port_arbiter;
   import mem_port_arbiter_pkg::*;

   localparam int N = 3;

   logic                     clk = 1'b0;
   logic                     rst;
   logic [N-1:0]             req_valid_In;
   logic [N*32-1:0]          req_addr_In;
   logic [N*32-1:0]          req_data_In;
   logic [N*2-1:0]           req_dataWidth_In;
   logic [N-1:0]             req_isRead_In;
   logic [N-1:0]             grant_Out;
   logic [N-1:0]             req_done_Out;
   logic [31:0]              req_data_Out;
   logic [EXCEPTION_LEN-1:0] req_exception_Out;
   logic [31:0]              m_addr_Out;
   logic [31:0]              m_data_Out;
   logic [1:0]               m_dataWidth_Out;
   logic                     m_isRead_Out;
   logic                     m_inputValid_Out;
   logic                     m_operationOK_In;
   logic [31:0]              m_data_In;
   logic [EXCEPTION_LEN-1:0] m_exception_In;

   int checks   = 0;
   int failures = 0;

   mem_port_arbiter #(.N_REQ(N), .TIMEOUT(4)) dut (
      .clk               (clk),
      .rst               (rst),
      .req_valid_In      (req_valid_In),
      .req_addr_In       (req_addr_In),
      .req_data_In       (req_data_In),
      .req_dataWidth_In  (req_dataWidth_In),
      .req_isRead_In     (req_isRead_In),
      .grant_Out         (grant_Out),
      .req_done_Out      (req_done_Out),
      .req_data_Out      (req_data_Out),
      .req_exception_Out (req_exception_Out),
      .m_addr_Out        (m_addr_Out),
      .m_data_Out        (m_data_Out),
      .m_dataWidth_Out   (m_dataWidth_Out),
      .m_isRead_Out      (m_isRead_Out),
      .m_inputValid_Out  (m_inputValid_Out),
      .m_operationOK_In  (m_operationOK_In),
      .m_data_In         (m_data_In),
      .m_exception_In    (m_exception_In)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input int idx, input logic [31:0] addr,
                                input logic [31:0] data, input logic [1:0] width,
                                input logic is_read);
      req_addr_In[32*idx +: 32]    = addr;
      req_data_In[32*idx +: 32]    = data;
      req_dataWidth_In[2*idx +: 2] = width;
      req_isRead_In[idx]           = is_read;
   endtask

   initial begin
      logic [N-1:0] exp_grant;

      rst              = 1'b1;
      req_valid_In     = '0;
      req_addr_In      = '0;
      req_data_In      = '0;
      req_dataWidth_In = '0;
      req_isRead_In    = '0;
      m_operationOK_In = 1'b0;
      m_data_In        = '0;
      m_exception_In   = EXCEP_OK;

      // Reset state
      tick();
      tick();
      checkOutput("rst_grant", 32'(grant_Out), 32'h0);
      checkOutput("rst_done", 32'(req_done_Out), 32'h0);
      checkOutput("rst_valid", 32'(m_inputValid_Out), 32'h0);
      checkOutput("rst_exc", 32'(req_exception_Out), 32'(EXCEP_OK));
      checkOutput("rst_addr", m_addr_Out, 32'h0);
      rst = 1'b0;

      // Round-robin fairness: all three valid, each drops after its done
      applyStimulus(0, 32'h0000_1000, 32'h0, MEM_WIDTH_WORD, 1'b1);
      applyStimulus(1, 32'h0000_2000, 32'h0, MEM_WIDTH_WORD, 1'b1);
      applyStimulus(2, 32'h0000_3000, 32'h0, MEM_WIDTH_WORD, 1'b1);
      req_valid_In = 3'b111;
      for (int j = 0; j < N; j++) begin
         exp_grant = 3'b001 << j;
         tick();
         checkOutput($sformatf("rr_grant%0d", j), 32'(grant_Out), 32'(exp_grant));
         checkOutput($sformatf("rr_addr%0d", j), m_addr_Out, 32'h0000_1000 * (j + 1));
         m_operationOK_In = 1'b1;
         m_data_In        = 32'h100 + j;
         tick();
         checkOutput($sformatf("rr_done%0d", j), 32'(req_done_Out), 32'(exp_grant));
         checkOutput($sformatf("rr_data%0d", j), req_data_Out, 32'h100 + j);
         m_operationOK_In = 1'b0;
         req_valid_In[j]  = 1'b0;
         tick();
      end
      checkOutput("rr_idle_grant", 32'(grant_Out), 32'h0);

      // Single read by requester 1
      applyStimulus(1, 32'h4000_0010, 32'h0, MEM_WIDTH_WORD, 1'b1);
      req_valid_In = 3'b010;
      tick();
      checkOutput("rd_grant", 32'(grant_Out), 32'h2);
      checkOutput("rd_mvalid", 32'(m_inputValid_Out), 32'h1);
      checkOutput("rd_maddr", m_addr_Out, 32'h4000_0010);
      checkOutput("rd_width", 32'(m_dataWidth_Out), 32'(MEM_WIDTH_WORD));
      checkOutput("rd_isread", 32'(m_isRead_Out), 32'h1);
      m_operationOK_In = 1'b1;
      m_data_In        = 32'hDEAD_BEEF;
      req_valid_In     = 3'b000;
      tick();
      checkOutput("rd_done", 32'(req_done_Out), 32'h2);
      checkOutput("rd_data", req_data_Out, 32'hDEAD_BEEF);
      checkOutput("rd_exc", 32'(req_exception_Out), 32'(EXCEP_OK));
      checkOutput("rd_mvalid_low", 32'(m_inputValid_Out), 32'h0);
      m_operationOK_In = 1'b0;
      m_data_In        = '0;
      tick();
      checkOutput("rd_done_pulse", 32'(req_done_Out), 32'h0);
      checkOutput("rd_grant_idle", 32'(grant_Out), 32'h0);

      // Mask: requester 0 alone keeps valid high after done
      applyStimulus(0, 32'h0000_0040, 32'h0, MEM_WIDTH_WORD, 1'b1);
      req_valid_In = 3'b001;
      tick();
      checkOutput("mask_grant1", 32'(grant_Out), 32'h1);
      m_operationOK_In = 1'b1;
      tick();
      checkOutput("mask_done", 32'(req_done_Out), 32'h1);
      m_operationOK_In = 1'b0;
      tick();
      checkOutput("mask_idle1_grant", 32'(grant_Out), 32'h0);
      checkOutput("mask_idle1_mvalid", 32'(m_inputValid_Out), 32'h0);
      tick();
      checkOutput("mask_idle2_grant", 32'(grant_Out), 32'h0);
      tick();
      checkOutput("mask_regrant", 32'(grant_Out), 32'h1);
      checkOutput("mask_regrant_mvalid", 32'(m_inputValid_Out), 32'h1);
      m_operationOK_In = 1'b1;
      req_valid_In     = 3'b000;
      tick();
      m_operationOK_In = 1'b0;
      tick();

      // Exception: requester 2 word write to a misaligned address
      applyStimulus(2, 32'h4000_0002, 32'h1234_5678, MEM_WIDTH_WORD, 1'b0);
      req_valid_In = 3'b100;
      tick();
      checkOutput("exc_grant", 32'(grant_Out), 32'h4);
      checkOutput("exc_isread", 32'(m_isRead_Out), 32'h0);
      checkOutput("exc_mdata", m_data_Out, 32'h1234_5678);
      m_exception_In = EXCEP_INVALID_MEM_WRITE;
      m_data_In      = 32'hFFFF_FFFF;
      req_valid_In   = 3'b000;
      tick();
      checkOutput("exc_done", 32'(req_done_Out), 32'h4);
      checkOutput("exc_code", 32'(req_exception_Out), 32'(EXCEP_INVALID_MEM_WRITE));
      checkOutput("exc_data", req_data_Out, 32'h0);
      m_exception_In = EXCEP_OK;
      m_data_In      = '0;
      tick();

      // Timeout: router never answers a read from requester 0
      applyStimulus(0, 32'h0000_0100, 32'h0, MEM_WIDTH_BYTE, 1'b1);
      req_valid_In = 3'b001;
      tick();
      checkOutput("to_c1_grant", 32'(grant_Out), 32'h1);
      req_valid_In = 3'b000;
      tick();
      tick();
      tick();
      checkOutput("to_c4_mvalid", 32'(m_inputValid_Out), 32'h1);
      checkOutput("to_c4_done", 32'(req_done_Out), 32'h0);
      tick();
      checkOutput("to_c5_done", 32'(req_done_Out), 32'h1);
      checkOutput("to_c5_exc", 32'(req_exception_Out), 32'(EXCEP_INVALID_MEM_READ));
      checkOutput("to_c5_data", req_data_Out, 32'h0);
      tick();

      // Reset in the first BUSY cycle abandons the transaction
      applyStimulus(1, 32'h0000_0200, 32'hCAFE_0001, MEM_WIDTH_HALF, 1'b0);
      req_valid_In = 3'b010;
      tick();
      checkOutput("rm_busy_mvalid", 32'(m_inputValid_Out), 32'h1);
      rst              = 1'b1;
      m_operationOK_In = 1'b1;
      tick();
      checkOutput("rm_done", 32'(req_done_Out), 32'h0);
      checkOutput("rm_mvalid", 32'(m_inputValid_Out), 32'h0);
      checkOutput("rm_grant", 32'(grant_Out), 32'h0);
      checkOutput("rm_maddr", m_addr_Out, 32'h0);
      checkOutput("rm_mdata", m_data_Out, 32'h0);
      checkOutput("rm_width", 32'(m_dataWidth_Out), 32'h0);
      rst              = 1'b0;
      m_operationOK_In = 1'b0;
      applyStimulus(0, 32'h0000_0300, 32'h0, MEM_WIDTH_WORD, 1'b1);
      req_valid_In = 3'b011;
      tick();
      checkOutput("rm_first_grant", 32'(grant_Out), 32'h1);
      checkOutput("rm_first_addr", m_addr_Out, 32'h0000_0300);
      m_operationOK_In = 1'b1;
      req_valid_In     = 3'b000;
      tick();
      checkOutput("rm_first_done", 32'(req_done_Out), 32'h1);
      m_operationOK_In = 1'b0;
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
